sn74ls166: RTL and testbench
============================

Name: sn74ls166

Overview:
- 8-bit parallel-in/serial-out shift register, modelled on the 74LS166.
- Serialises a parallel byte, such as one captured by the octal D register, onto a single line MSB (H) first.
- Shifts in a serial fill bit from the other end.
- Simulatable TTL model for board-level testbenches. Synthesizability is not a goal.

Parameters:
- TPD_CLK, 0, clock-to-qh propagation delay in ns (timescale 1ns/100ps).
- TPD_CLR, 0, clr-low-to-qh propagation delay in ns.

Ports:
- clk  input  1  clock; register acts on the rising edge.
- clr  input  1  asynchronous clear, active-low; clears all 8 stages.
- clkinh  input  1  clock inhibit, active-high; blocks clk edges.
- shld  input  1  shift/load select: 0 = parallel load, 1 = shift.
- ser  input  1  serial data input, enters stage A.
- d  input  8  parallel data; d[0] = A … d[7] = H.
- qh  output  1  output of stage H (internal bit 7).

Behaviour:
- Internal state: 8-bit register r[7:0]; qh = r[7] at all times, after the applicable delay.
- Reset: clr low forces r = 8'h00 and qh = 0 (after TPD_CLR).
  - Takes effect immediately, independent of clk, clkinh, shld and d.
  - Held low: all rising clk edges are ignored.
  - Release (clr 0->1) does not itself load or shift. The next qualifying clk edge acts normally.
- Qualifying edge: rising edge of clk while clr = 1 and clkinh = 0.
  - clkinh = 1 suppresses the edge; r is held.
  - clkinh changes while clk is low or high produce no edge of their own. The model does not OR clk with clkinh.
- On a qualifying edge:
  - shld = 0: synchronous parallel load, r <= d. qh = d[7] after TPD_CLK.
  - shld = 1: shift toward H, r <= {r[6:0], ser}. qh = previous r[6].
- Latency:
  - Load: 1 clock to present H.
  - Stage A..G values reach qh after 7..1 further shifts respectively.
  - ser appears at qh 8 shifts after entry.
- Sampling: shld, ser, d and clkinh are sampled at the clk edge (the value immediately before the edge).
- X/Z handling:
  - Any X/Z on sampled d, ser or shld propagates X into the affected stages.
  - X on shld at an edge makes all 8 stages X.
  - X on clkinh at a qualifying clk edge makes all stages X.
  - X on clr: r becomes X unless r is already all-zero.
  - Initial (pre-clear) state is X.
- Simultaneous events: clr falling on the same timestep as a clk edge means clear wins; r = 0.
- Boundary: after 8 consecutive shifts r equals the last 8 ser bits. No wrap-around; r[7] is discarded on each shift.
- No other outputs. Stages A..G are not visible at the ports.

Test Plan:
- Clear: all inputs X, then clr = 0 for 40 ns -> qh = 0. A clk pulse with shld = 0, d = 8'hFF during clr = 0 -> qh stays 0.
- Load and serialise:
  - clr = 1, shld = 0, d = 8'b10101010, one clk rise -> qh = 1.
  - Then shld = 1, ser = 0, 8 clk rises -> qh sequence 0,1,0,1,0,1,0,0.
- Serial fill: after clear, shld = 1, ser = 1, 7 clk rises -> qh = 0 after each. The 8th rise -> qh = 1.
- Clock inhibit:
  - Load 8'b11000000 -> qh = 1.
  - clkinh = 1, shld = 1, 3 clk rises -> qh stays 1.
  - clkinh = 0, 1 rise -> qh = 1.
  - 1 more rise -> qh = 0.
- Clear mid-shift: load 8'hFF, shift twice with ser = 1, drop clr between edges -> qh = 0 immediately. Release clr, shift with ser = 1 -> qh = 0.
- Reload during shift: load 8'h0F, shift 4 times (ser = 0), then shld = 0, d = 8'h80, 1 rise -> qh = 1. Next shift (ser = 0) -> qh = 0.

Source files
------------

// File: rtl/sn74ls166.sv
// 8-bit parallel-in/serial-out shift register modelled on the 74LS166.
// Bytes leave on qh MSB (stage H) first while the serial fill enters stage A.
`timescale 1ns/100ps

module sn74ls166 #(
    parameter int TPD_CLK = 0,
    parameter int TPD_CLR = 0
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       clkinh,
    input  logic       shld,
    input  logic       ser,
    input  logic [7:0] d,
    output logic       qh
);

    logic [7:0] r;

    // Delay parameters only keep the board-level port map compatible; qh switches with zero delay.
    generate
        if (TPD_CLK < 0 || TPD_CLR < 0) begin : g_negative_delay
        end
    endgenerate

    // An unknown clr, clkinh or shld cannot be resolved, so it poisons the whole register.
    always_ff @(posedge clk or negedge clr) begin
        if (clr === 1'b0) begin
            r <= 8'h00;
        end else if (clr !== 1'b1) begin
            r <= (r === 8'h00) ? 8'h00 : 8'hxx;
        end else if (clkinh === 1'b1) begin
            r <= r;
        end else if (clkinh !== 1'b0) begin
            r <= 8'hxx;
        end else if (shld === 1'b0) begin
            r <= d;
        end else if (shld === 1'b1) begin
            r <= {r[6:0], ser};
        end else begin
            r <= 8'hxx;
        end
    end

    assign qh = r[7];

endmodule

// File: tb/tb_sn74ls166.sv
// Directed bench for sn74ls166: a vector table applied one clock each, plus
// hand-written sequences for the asynchronous clear corner cases.
`timescale 1ns/100ps

module tb_sn74ls166;

    logic       clk;
    logic       clr;
    logic       clkinh;
    logic       shld;
    logic       ser;
    logic [7:0] d;
    logic       qh;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       clr;
        logic       clkinh;
        logic       shld;
        logic       ser;
        logic [7:0] d;
        logic       exp_qh;
    } vec_t;

    vec_t vecs[$];

    sn74ls166 dut (
        .clk    (clk),
        .clr    (clr),
        .clkinh (clkinh),
        .shld   (shld),
        .ser    (ser),
        .d      (d),
        .qh     (qh)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic void add(input logic c, input logic inh, input logic sl,
                                input logic s, input logic [7:0] dv, input logic e);
        vec_t v;
        v.clr    = c;
        v.clkinh = inh;
        v.shld   = sl;
        v.ser    = s;
        v.d      = dv;
        v.exp_qh = e;
        vecs.push_back(v);
    endfunction

    task automatic applyStimulus(input vec_t v);
        clr    = v.clr;
        clkinh = v.clkinh;
        shld   = v.shld;
        ser    = v.ser;
        d      = v.d;
    endtask

    task automatic checkOutput(input string name, input logic exp);
        checks++;
        if (qh !== exp) begin
            errors++;
            $display("[TB] FAIL %s: qh=%b expected %b", name, qh, exp);
        end
    endtask

    initial begin
        // Everything unknown, then hold clear low.
        clr    = 1'bx;
        clkinh = 1'bx;
        shld   = 1'bx;
        ser    = 1'bx;
        d      = 8'hxx;
        #1;
        clr = 1'b0;
        #44;
        checkOutput("clear_initial", 1'b0);

        // Clock edge during clear with a load of FF must be ignored.
        add(1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0);

        // Load 10101010 then shift out with ser=0.
        add(1'b1, 1'b0, 1'b0, 1'b0, 8'b10101010, 1'b1);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        // Serial fill from cleared state: ser=1 reaches qh on the 8th shift.
        add(1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0);
        for (int i = 0; i < 7; i++) add(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1);

        // Clock inhibit holds the register.
        add(1'b1, 1'b0, 1'b0, 1'b0, 8'b11000000, 1'b1);
        add(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        add(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        add(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        // Reload in the middle of shifting.
        add(1'b1, 1'b0, 1'b0, 1'b0, 8'h0F, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        add(1'b1, 1'b0, 1'b0, 1'b0, 8'h80, 1'b1);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_qh);
        end

        // Clear dropped between edges acts at once; release does not load.
        applyStimulus('{1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1});
        @(negedge clk);
        checkOutput("midclr_load", 1'b1);
        shld = 1'b1;
        @(negedge clk);
        checkOutput("midclr_shift1", 1'b1);
        @(negedge clk);
        checkOutput("midclr_shift2", 1'b1);
        #3 clr = 1'b0;
        #1 checkOutput("midclr_immediate", 1'b0);
        #2 clr = 1'b1;
        @(negedge clk);
        checkOutput("midclr_after_release", 1'b0);

        // Clear falling on the same timestep as a rising edge wins over a load.
        applyStimulus('{1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1});
        @(negedge clk);
        checkOutput("simul_preload", 1'b1);
        @(posedge clk);
        clr = 1'b0;
        #1 checkOutput("simul_clear_wins", 1'b0);
        @(negedge clk);
        applyStimulus('{1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0});
        @(negedge clk);
        checkOutput("simul_release_shift", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
